// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for pipelined_cpu_core: the 4-bit opcode encoding and
//   small decode helpers used by the execute stage.
//   Instruction layout (MSB..LSB): {op[3:0], rd, rs1, rs2, imm[REGISTER_WIDTH-1:0]}
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned OPCODE_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP        = 4'd0,
        OP_LD         = 4'd1,
        OP_ADD        = 4'd2,
        OP_INC        = 4'd3,
        OP_DEC        = 4'd4,
        OP_LSHIFT     = 4'd5,
        OP_RSHIFT     = 4'd6,
        OP_LOADSWITCH = 4'd7,
        OP_JMP        = 4'd8,
        OP_JZ         = 4'd9,
        OP_JR         = 4'd10,
        OP_RST        = 4'd11,
        OP_HALT       = 4'd12
    } opcode_e;

    // Opcodes that produce a register-file write.
    function automatic logic writes_rd(opcode_e op);
        case (op)
            OP_LD, OP_ADD, OP_INC, OP_DEC,
            OP_LSHIFT, OP_RSHIFT, OP_LOADSWITCH: writes_rd = 1'b1;
            default:                             writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_if.sv
// ---------------------------------------------------------------------------
// cpu_if
//   Instruction-memory fetch port of pipelined_cpu_core.
//   imemAddress  core -> mem  fetch address (current pc)
//   imemRequest  core -> mem  fetch request (not halted, not in reset)
//   imemReady    mem -> core  imemData valid for imemAddress this cycle
//   imemData     mem -> core  instruction word
// ---------------------------------------------------------------------------
interface cpu_if #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned IW       = 21
);
    logic [PC_WIDTH-1:0] imemAddress;
    logic                imemRequest;
    logic                imemReady;
    logic [IW-1:0]       imemData;

    modport master (output imemAddress, output imemRequest,
                    input  imemReady,   input  imemData);
    modport slave  (input  imemAddress, input  imemRequest,
                    output imemReady,   output imemData);
endinterface

// File: rtl/cpu_regfile.sv
// ---------------------------------------------------------------------------
// cpu_regfile
//   N x W register file, two async read ports plus a debug read port, one
//   synchronous write port. r0 is hard zero. Synchronous clear on isReset.
//   clock, isReset       clock / sync active-high reset
//   rs1_idx_i/rs2_idx_i  read addresses -> rs1_data_o/rs2_data_o
//   dbg_idx_i            debug address  -> dbg_data_o
//   we_i, wd_idx_i, wdata_i  write port
// ---------------------------------------------------------------------------
module cpu_regfile #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 8,
    localparam int unsigned RIDX = $clog2(N)
) (
    input  logic            clock,
    input  logic            isReset,
    input  logic [RIDX-1:0] rs1_idx_i,
    input  logic [RIDX-1:0] rs2_idx_i,
    input  logic [RIDX-1:0] dbg_idx_i,
    input  logic            we_i,
    input  logic [RIDX-1:0] wd_idx_i,
    input  logic [W-1:0]    wdata_i,
    output logic [W-1:0]    rs1_data_o,
    output logic [W-1:0]    rs2_data_o,
    output logic [W-1:0]    dbg_data_o
);
    logic [W-1:0] regs_q [N];
    logic [N-1:0] wen;

    // Per-register write enables; r0 never enabled so it stays zero.
    for (genvar g = 0; g < N; g++) begin : g_wen
        if (g == 0) begin : g_zero
            assign wen[g] = 1'b0;
        end else begin : g_reg
            assign wen[g] = we_i && (wd_idx_i == RIDX'(g));
        end
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            for (int unsigned i = 0; i < N; i++) regs_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wen[i]) regs_q[i] <= wdata_i;
            end
        end
    end

    assign rs1_data_o = regs_q[rs1_idx_i];
    assign rs2_data_o = regs_q[rs2_idx_i];
    assign dbg_data_o = regs_q[dbg_idx_i];

endmodule

// File: rtl/pipelined_cpu_core.sv
// ---------------------------------------------------------------------------
// pipelined_cpu_core
//   Two-stage (FETCH, EXECUTE) core with register file, ALU and branch unit.
//   clock, isReset  clock / synchronous active-high reset
//   imem            cpu_if.master fetch port (address, request, ready, data)
//   switch          board switch, read by LOADSWITCH
//   debugIndex      register selected for debugValue (combinational read)
//   pc              current fetch pc
//   halted          core stopped by HALT; only isReset leaves it
// ---------------------------------------------------------------------------
module pipelined_cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH      = 8,
    parameter int unsigned NUMBER_OF_REGISTERS = 8,
    parameter int unsigned PC_WIDTH            = 8,
    localparam int unsigned RIDX = $clog2(NUMBER_OF_REGISTERS),
    localparam int unsigned IW   = OPCODE_WIDTH + 3*RIDX + REGISTER_WIDTH
) (
    input  logic                      clock,
    input  logic                      isReset,
    cpu_if.master                     imem,
    input  logic                      switch,
    input  logic [RIDX-1:0]           debugIndex,
    output logic [REGISTER_WIDTH-1:0] debugValue,
    output logic [PC_WIDTH-1:0]       pc,
    output logic                      halted
);
    localparam int unsigned RW = REGISTER_WIDTH;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                ex_valid_q, ex_valid_d;
    logic [IW-1:0]       ex_instr_q, ex_instr_d;
    logic                halted_q, halted_d;

    logic fetch_req, fetch_fire;

    opcode_e             ex_op;
    logic [RIDX-1:0]     ex_rd, ex_rs1, ex_rs2;
    logic [RW-1:0]       ex_imm;
    logic [PC_WIDTH-1:0] imm_pc;
    logic [RW-1:0]       rs1_data, rs2_data;
    logic                rf_we;
    logic [RW-1:0]       rf_wdata;

    assign fetch_req  = ~halted_q & ~isReset;
    assign fetch_fire = fetch_req & imem.imemReady;

    assign imem.imemAddress = pc_q;
    assign imem.imemRequest = fetch_req;
    assign pc               = pc_q;
    assign halted           = halted_q;

    assign ex_op  = opcode_e'(ex_instr_q[IW-1 -: OPCODE_WIDTH]);
    assign ex_rd  = ex_instr_q[IW-OPCODE_WIDTH-1 -: RIDX];
    assign ex_rs1 = ex_instr_q[IW-OPCODE_WIDTH-RIDX-1 -: RIDX];
    assign ex_rs2 = ex_instr_q[IW-OPCODE_WIDTH-2*RIDX-1 -: RIDX];
    assign ex_imm = ex_instr_q[RW-1:0];
    assign imm_pc = PC_WIDTH'(ex_imm);

    cpu_regfile #(
        .W (RW),
        .N (NUMBER_OF_REGISTERS)
    ) u_regfile (
        .clock      (clock),
        .isReset    (isReset),
        .rs1_idx_i  (ex_rs1),
        .rs2_idx_i  (ex_rs2),
        .dbg_idx_i  (debugIndex),
        .we_i       (rf_we),
        .wd_idx_i   (ex_rd),
        .wdata_i    (rf_wdata),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .dbg_data_o (debugValue)
    );

    // ALU / writeback
    always_comb begin
        rf_wdata = '0;
        case (ex_op)
            OP_LD:         rf_wdata = ex_imm;
            OP_ADD:        rf_wdata = rs1_data + rs2_data;
            OP_INC:        rf_wdata = rs1_data + RW'(1);
            OP_DEC:        rf_wdata = rs1_data - RW'(1);
            OP_LSHIFT:     rf_wdata = {rs1_data[RW-2:0], 1'b0};
            OP_RSHIFT:     rf_wdata = {1'b0, rs1_data[RW-1:1]};
            OP_LOADSWITCH: rf_wdata = RW'(switch);
            default:       rf_wdata = '0;
        endcase
        rf_we = ex_valid_q && writes_rd(ex_op);
    end

    // Fetch / branch / halt next state. Later assignments take priority:
    // fetch increment < taken branch < HALT.
    always_comb begin
        pc_d       = pc_q;
        ex_valid_d = 1'b0;
        ex_instr_d = ex_instr_q;
        halted_d   = halted_q;

        if (fetch_fire) begin
            ex_instr_d = imem.imemData;
            ex_valid_d = 1'b1;
            pc_d       = pc_q + PC_WIDTH'(1);
        end

        if (ex_valid_q) begin
            case (ex_op)
                OP_JMP: begin
                    pc_d       = imm_pc;
                    ex_valid_d = 1'b0;
                end
                OP_JZ: begin
                    if (rs1_data == '0) begin
                        pc_d       = imm_pc;
                        ex_valid_d = 1'b0;
                    end
                end
                OP_JR: begin
                    pc_d       = PC_WIDTH'(rs1_data);
                    ex_valid_d = 1'b0;
                end
                OP_RST: begin
                    pc_d       = '0;
                    ex_valid_d = 1'b0;
                end
                OP_HALT: begin
                    pc_d       = pc_q;
                    ex_valid_d = 1'b0;
                    halted_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            pc_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ex_valid_q <= ex_valid_d;
            ex_instr_q <= ex_instr_d;
            halted_q   <= halted_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cpu_core
//   Directed cycle-level scenarios plus random programs checked against an
//   instruction-level reference model of the ISA.
// ---------------------------------------------------------------------------
module tb_pipelined_cpu_core;
    import cpu_pkg::*;

    localparam int unsigned RW   = 8;
    localparam int unsigned NR   = 8;
    localparam int unsigned PW   = 8;
    localparam int unsigned RIDX = 3;
    localparam int unsigned IW   = 4 + 3*RIDX + RW;

    logic            clock = 1'b0;
    logic            isReset = 1'b1;
    logic            switch = 1'b0;
    logic [RIDX-1:0] debugIndex = '0;
    logic [RW-1:0]   debugValue;
    logic [PW-1:0]   pc;
    logic            halted;

    cpu_if #(.PC_WIDTH(PW), .IW(IW)) imem_bus ();

    logic [IW-1:0] mem [256];

    int ntests = 0;
    int nfail  = 0;

    logic [RW-1:0] exp_regs [NR];
    logic [PW-1:0] exp_pc;
    bit            exp_ok;

    always #5 clock = ~clock;

    // Combinational instruction memory
    always_comb imem_bus.imemData = mem[imem_bus.imemAddress];

    pipelined_cpu_core #(
        .REGISTER_WIDTH      (RW),
        .NUMBER_OF_REGISTERS (NR),
        .PC_WIDTH            (PW)
    ) dut (
        .clock      (clock),
        .isReset    (isReset),
        .imem       (imem_bus),
        .switch     (switch),
        .debugIndex (debugIndex),
        .debugValue (debugValue),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [RW-1:0] expv);
        logic [RIDX-1:0] sel;
        sel = RIDX'(idx);
        debugIndex = sel;
        #1;
        check(tag, 32'(debugValue), 32'(expv));
    endtask

    function automatic logic [IW-1:0] ins(opcode_e op, int rd, int rs1, int rs2, int imm);
        ins = {op, rd[2:0], rs1[2:0], rs2[2:0], imm[7:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        isReset = 1'b1;
        tick(2);
        check("req_in_reset", 32'(imem_bus.imemRequest), 0);
        isReset = 1'b0;
        #1;
    endtask

    // Instruction-level reference: executes one instruction at a time in
    // program order; the pipeline must match this architecturally.
    task automatic iss_run();
        logic [PW-1:0] p, pn;
        logic [IW-1:0] w;
        logic [RIDX-1:0] rd, a, b;
        logic [RW-1:0] imm, va, res;
        bit wr;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        p = '0;
        exp_ok = 1'b0;
        exp_pc = '0;
        for (int step = 0; step < 2000 && !exp_ok; step++) begin
            w   = mem[p];
            rd  = w[16:14];
            a   = w[13:11];
            b   = w[10:8];
            imm = w[7:0];
            va  = exp_regs[a];
            wr  = 1'b0;
            res = '0;
            pn  = p + 8'd1;
            case (opcode_e'(w[20:17]))
                OP_LD:         begin wr = 1'b1; res = imm; end
                OP_ADD:        begin wr = 1'b1; res = va + exp_regs[b]; end
                OP_INC:        begin wr = 1'b1; res = va + 8'd1; end
                OP_DEC:        begin wr = 1'b1; res = va - 8'd1; end
                OP_LSHIFT:     begin wr = 1'b1; res = va * 8'd2; end
                OP_RSHIFT:     begin wr = 1'b1; res = va / 8'd2; end
                OP_LOADSWITCH: begin wr = 1'b1; res = {7'd0, switch}; end
                OP_JMP:        pn = imm;
                OP_JZ:         if (va == 8'd0) pn = imm;
                OP_JR:         pn = va;
                OP_RST:        pn = '0;
                OP_HALT:       begin exp_ok = 1'b1; exp_pc = p + 8'd1; end
                default:       ;
            endcase
            if (wr && rd != 0) exp_regs[rd] = res;
            p = pn;
        end
    endtask

    // Reset, run with random imemReady until HALT (bounded), compare with model.
    task automatic run_prog(input string name);
        bit done;
        do_reset();
        iss_run();
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            imem_bus.imemReady = ($urandom_range(0, 3) != 0);
            tick(1);
            if (halted) done = 1'b1;
        end
        imem_bus.imemReady = 1'b1;
        check({name, "_halted"}, 32'(halted), 1);
        if (exp_ok) begin
            check({name, "_pc"}, 32'(pc), 32'(exp_pc));
            for (int r = 0; r < NR; r++)
                check_reg($sformatf("%s_r%0d", name, r), r, exp_regs[r]);
        end
    endtask

    task automatic gen_random_prog();
        int len, k, tgt;
        clear_mem();
        len = $urandom_range(4, 40);
        for (int i = 0; i < len; i++) begin
            k   = $urandom_range(0, 11);
            tgt = $urandom_range(i + 1, len);
            case (k)
                0:  mem[i] = ins(OP_NOP, 0, 0, 0, 0);
                1, 11: mem[i] = ins(OP_LD, $urandom_range(0, 7), 0, 0, $urandom_range(0, 255));
                2:  mem[i] = ins(OP_ADD, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
                3:  mem[i] = ins(OP_INC, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
                4:  mem[i] = ins(OP_DEC, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
                5:  mem[i] = ins(OP_LSHIFT, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
                6:  mem[i] = ins(OP_RSHIFT, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
                7:  mem[i] = ins(OP_LOADSWITCH, $urandom_range(0, 7), 0, 0, 0);
                8:  mem[i] = ins(OP_JMP, 0, 0, 0, tgt);
                9:  mem[i] = ins(OP_JZ, 0, $urandom_range(0, 7), 0, tgt);
                default: mem[i] = ins(opcode_e'(4'($urandom_range(13, 15))), $urandom_range(1, 7), 0, 0, $urandom_range(0, 255));
            endcase
        end
        mem[len] = ins(OP_HALT, 0, 0, 0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_bus.imemReady = 1'b1;
        clear_mem();

        // 1: back-to-back LD/LD/ADD
        mem[0] = ins(OP_LD, 1, 0, 0, 5);
        mem[1] = ins(OP_LD, 2, 0, 0, 7);
        mem[2] = ins(OP_ADD, 3, 1, 2, 0);
        mem[3] = ins(OP_HALT, 0, 0, 0, 0);
        do_reset();
        check("rst_pc", 32'(pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_req", 32'(imem_bus.imemRequest), 1);
        check_reg("rst_r1", 1, 0);
        tick(3);
        check_reg("t1_r3_c3", 3, 0);
        tick(1);
        check_reg("t1_r3_c4", 3, 12);
        check("t1_pc_c4", 32'(pc), 4);
        tick(1);
        check("t1_halted", 32'(halted), 1);
        check("t1_pc_halt", 32'(pc), 4);
        check("t1_req_halt", 32'(imem_bus.imemRequest), 0);

        // 2: fetch stalls between two INCs
        clear_mem();
        mem[0] = ins(OP_INC, 1, 1, 0, 0);
        mem[1] = ins(OP_INC, 1, 1, 0, 0);
        mem[2] = ins(OP_HALT, 0, 0, 0, 0);
        do_reset();
        tick(1);
        imem_bus.imemReady = 1'b0;
        tick(1);
        check("t2_pc_stall1", 32'(pc), 1);
        check_reg("t2_r1_stall1", 1, 1);
        tick(2);
        check("t2_pc_stall3", 32'(pc), 1);
        check_reg("t2_r1_stall3", 1, 1);
        imem_bus.imemReady = 1'b1;
        tick(3);
        check("t2_halted", 32'(halted), 1);
        check_reg("t2_r1", 1, 2);
        check("t2_pc", 32'(pc), 3);

        // 3: taken JZ flushes the wrong-path LD
        clear_mem();
        mem[0]    = ins(OP_LD, 1, 0, 0, 0);
        mem[1]    = ins(OP_JZ, 0, 1, 0, 8'h10);
        mem[2]    = ins(OP_LD, 2, 0, 0, 9);
        mem[8'h10] = ins(OP_HALT, 0, 0, 0, 0);
        do_reset();
        tick(3);
        check("t3_pc_target", 32'(pc), 32'h10);
        tick(1);
        check("t3_pc_after", 32'(pc), 32'h11);
        check("t3_bubble", 32'(halted), 0);
        tick(1);
        check("t3_halted", 32'(halted), 1);
        check_reg("t3_r2", 2, 0);

        // 4: wrap, shift, r0 write discard
        clear_mem();
        mem[0] = ins(OP_LD, 1, 0, 0, 255);
        mem[1] = ins(OP_INC, 1, 1, 0, 0);
        mem[2] = ins(OP_LD, 2, 0, 0, 8'h81);
        mem[3] = ins(OP_RSHIFT, 3, 2, 0, 0);
        mem[4] = ins(OP_LD, 0, 0, 0, 5);
        mem[5] = ins(OP_HALT, 0, 0, 0, 0);
        run_prog("t4");
        check_reg("t4_r1_wrap", 1, 0);
        check_reg("t4_r3_rshift", 3, 8'h40);
        check_reg("t4_r0", 0, 0);

        // 5: HALT freezes until reset
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t5_pc_frozen", 32'(pc), 6);
            check("t5_halted", 32'(halted), 1);
            check("t5_req", 32'(imem_bus.imemRequest), 0);
        end
        isReset = 1'b1;
        tick(1);
        isReset = 1'b0;
        #1;
        check("t5_rst_pc", 32'(pc), 0);
        check("t5_rst_halted", 32'(halted), 0);
        check("t5_rst_req", 32'(imem_bus.imemRequest), 1);
        for (int r = 0; r < NR; r++) check_reg($sformatf("t5_rst_r%0d", r), r, 0);

        // 6: reset beats JMP in EX; then LOADSWITCH
        clear_mem();
        mem[0]    = ins(OP_LD, 5, 0, 0, 3);
        mem[1]    = ins(OP_JMP, 0, 0, 0, 8'h20);
        mem[8'h20] = ins(OP_HALT, 0, 0, 0, 0);
        do_reset();
        tick(2);
        isReset = 1'b1;
        tick(1);
        check("t6_pc_rst", 32'(pc), 0);
        check_reg("t6_r5_rst", 5, 0);
        clear_mem();
        mem[0] = ins(OP_LOADSWITCH, 4, 0, 0, 0);
        mem[1] = ins(OP_HALT, 0, 0, 0, 0);
        switch = 1'b1;
        isReset = 1'b0;
        tick(3);
        check("t6_halted", 32'(halted), 1);
        check_reg("t6_r4", 4, 1);

        // JR
        clear_mem();
        mem[0]    = ins(OP_LD, 6, 0, 0, 8'h30);
        mem[1]    = ins(OP_JR, 0, 6, 0, 0);
        mem[2]    = ins(OP_LD, 2, 0, 0, 1);
        mem[8'h30] = ins(OP_HALT, 0, 0, 0, 0);
        run_prog("jr");

        // RST loop with JZ taken then not taken
        clear_mem();
        mem[0] = ins(OP_INC, 7, 7, 0, 0);
        mem[1] = ins(OP_DEC, 6, 7, 0, 0);
        mem[2] = ins(OP_JZ, 0, 6, 0, 4);
        mem[3] = ins(OP_HALT, 0, 0, 0, 0);
        mem[4] = ins(OP_RST, 0, 0, 0, 0);
        run_prog("rst");

        // PC wrap 255 -> 0
        clear_mem();
        mem[0]    = ins(OP_JZ, 0, 2, 0, 8'hFE);
        mem[1]    = ins(OP_HALT, 0, 0, 0, 0);
        mem[8'hFE] = ins(OP_INC, 2, 2, 0, 0);
        mem[8'hFF] = ins(OP_LD, 1, 0, 0, 8'h11);
        run_prog("wrap");

        // Random programs
        for (int n = 0; n < 25; n++) begin
            switch = 1'($urandom_range(0, 1));
            gen_random_prog();
            run_prog($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
